// File: rtl/mcycle_ctrl_fsm_pkg.sv
// Shared state and opcode encodings for the multicycle controller.
// Output logic imports this too, so codes cannot drift apart.
package ctrl_pkg;

  localparam int STATEW = 4;

  localparam logic [STATEW-1:0] FETCH1  = 4'd0;
  localparam logic [STATEW-1:0] FETCH2  = 4'd1;
  localparam logic [STATEW-1:0] FETCH3  = 4'd2;
  localparam logic [STATEW-1:0] FETCH4  = 4'd3;
  localparam logic [STATEW-1:0] DECODE  = 4'd4;
  localparam logic [STATEW-1:0] MEMADR  = 4'd5;
  localparam logic [STATEW-1:0] LBRD    = 4'd6;
  localparam logic [STATEW-1:0] LBWR    = 4'd7;
  localparam logic [STATEW-1:0] SBWR    = 4'd8;
  localparam logic [STATEW-1:0] RTYPEEX = 4'd9;
  localparam logic [STATEW-1:0] RTYPEWR = 4'd10;
  localparam logic [STATEW-1:0] BEQEX   = 4'd11;
  localparam logic [STATEW-1:0] JEX     = 4'd12;
  localparam logic [STATEW-1:0] ADDIEX  = 4'd13;
  localparam logic [STATEW-1:0] ADDIWR  = 4'd14;
  localparam logic [STATEW-1:0] TRAP    = 4'd15;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  function automatic logic is_fetch(
    input logic [STATEW-1:0] s
  );
    return (s <= FETCH4);
  endfunction

endpackage

// File: rtl/mcycle_ctrl_fsm_decode.sv
// Opcode classifier for the DECODE and MEMADR transitions.
// Outputs are one-hot: exactly one flag is set for any op.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] i_op,
  output logic           o_is_lb,
  output logic           o_is_sb,
  output logic           o_is_rtype,
  output logic           o_is_beq,
  output logic           o_is_j,
  output logic           o_is_addi,
  output logic           o_is_illegal
);

  // exact-match compare against each known opcode
  always_comb begin
    o_is_lb    = (i_op == OPW'(OP_LB));
    o_is_sb    = (i_op == OPW'(OP_SB));
    o_is_rtype = (i_op == OPW'(OP_RTYPE));
    o_is_beq   = (i_op == OPW'(OP_BEQ));
    o_is_j     = (i_op == OPW'(OP_J));
    o_is_addi  = (i_op == OPW'(OP_ADDI));
    o_is_illegal = ~(o_is_lb | o_is_sb |
                     o_is_rtype | o_is_beq |
                     o_is_j | o_is_addi);
  end

endmodule

// File: rtl/mcycle_ctrl_fsm.sv
// Multicycle controller state register and next-state logic.
// ILLEGAL_OP_TRAP_EN: unknown opcodes park in TRAP until reset.
module mcycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int FETCH_BEATS = 4,
  parameter int OPW         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    op,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [STATEW-1:0] state,
  output logic              instr_done,
  output logic              illegal
);

  localparam logic [STATEW-1:0] LAST_FETCH =
    STATEW'(FETCH_BEATS - 1);

  logic [STATEW-1:0] r_state;
  logic [STATEW-1:0] w_next;
  logic              r_done;
  logic              r_illegal;
  logic              w_done_nxt;
  logic              w_ill_nxt;

  logic w_is_lb;
  logic w_is_sb;
  logic w_is_rtype;
  logic w_is_beq;
  logic w_is_j;
  logic w_is_addi;
  logic w_is_illegal;

  // branch resolution lives in output logic
  logic w_unused_zero;
  assign w_unused_zero = zero;

  ctrl_decode #(
    .OPW (OPW)
  ) u_dec (
    .i_op         (op),
    .o_is_lb      (w_is_lb),
    .o_is_sb      (w_is_sb),
    .o_is_rtype   (w_is_rtype),
    .o_is_beq     (w_is_beq),
    .o_is_j       (w_is_j),
    .o_is_addi    (w_is_addi),
    .o_is_illegal (w_is_illegal)
  );

  // state and flag registers, reset wins over everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= FETCH1;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= w_done_nxt;
      r_illegal <= w_ill_nxt;
    end
  end

  // next-state selection
  always_comb begin
    w_next = FETCH1;
    case (r_state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        if (r_state > LAST_FETCH)
          w_next = FETCH1;
        else if (!mem_ready)
          w_next = r_state;
        else if (r_state == LAST_FETCH)
          w_next = DECODE;
        else
          w_next = r_state + 4'd1;
      end
      DECODE: begin
        unique case (1'b1)
          w_is_lb, w_is_sb: w_next = MEMADR;
          w_is_rtype:       w_next = RTYPEEX;
          w_is_beq:         w_next = BEQEX;
          w_is_j:           w_next = JEX;
          w_is_addi:        w_next = ADDIEX;
`ifdef ILLEGAL_OP_TRAP_EN
          w_is_illegal:     w_next = TRAP;
`else
          w_is_illegal:     w_next = FETCH1;
`endif
          default:          w_next = FETCH1;
        endcase
      end
      MEMADR: begin
        if (w_is_lb)
          w_next = LBRD;
        else if (w_is_sb)
          w_next = SBWR;
        else
          w_next = FETCH1;
      end
      LBRD:    w_next = mem_ready ? LBWR : LBRD;
      SBWR:    w_next = mem_ready ? FETCH1 : SBWR;
      LBWR:    w_next = FETCH1;
      RTYPEEX: w_next = RTYPEWR;
      RTYPEWR: w_next = FETCH1;
      BEQEX:   w_next = FETCH1;
      JEX:     w_next = FETCH1;
      ADDIEX:  w_next = ADDIWR;
      ADDIWR:  w_next = FETCH1;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:    w_next = TRAP;
`endif
      default: w_next = FETCH1;
    endcase
  end

  // retire pulse, sticky illegal flag, port drive
  always_comb begin
    w_done_nxt = (w_next == FETCH1) &&
                 !is_fetch(r_state);
    w_ill_nxt  = r_illegal ||
                 ((r_state == DECODE) && w_is_illegal);
    state      = r_state;
    instr_done = r_done;
    illegal    = r_illegal;
  end

endmodule

// File: tb/tb_mcycle_ctrl_fsm.sv
// Bench for mcycle_ctrl_fsm: 4-beat and 1-beat fetch builds
// checked against a per-instruction path model.
module tb_mcycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op0, op1;
  logic       mr0, mr1;
  logic       zf;
  logic [3:0] st0, st1;
  logic       d0, d1, il0, il1;

  always #5 clk = ~clk;

  mcycle_ctrl_fsm #(
    .FETCH_BEATS (4),
    .OPW         (6)
  ) u_dut4 (
    .clk        (clk),
    .reset      (rst_n),
    .op         (op0),
    .zero       (zf),
    .mem_ready  (mr0),
    .state      (st0),
    .instr_done (d0),
    .illegal    (il0)
  );

  mcycle_ctrl_fsm #(
    .FETCH_BEATS (1),
    .OPW         (6)
  ) u_dut1 (
    .clk        (clk),
    .reset      (rst_n),
    .op         (op1),
    .zero       (zf),
    .mem_ready  (mr1),
    .state      (st1),
    .instr_done (d1),
    .illegal    (il1)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // model: each instruction is a list of state codes
  int path [2][16];
  int plen [2];
  int idx  [2];
  bit e_done [2];
  bit e_ill  [2];
  int beats  [2];

  function automatic void start_instr(int m);
    for (int i = 0; i < beats[m]; i++) path[m][i] = i;
    path[m][beats[m]] = 4;
    plen[m] = beats[m] + 1;
    idx[m]  = 0;
  endfunction

  function automatic void add(int m, int s);
    path[m][plen[m]] = s;
    plen[m]++;
  endfunction

  function automatic void add_tail(int m, logic [5:0] o);
    case (o)
      6'b100000: begin add(m, 5); add(m, 6); add(m, 7); end
      6'b101000: begin add(m, 5); add(m, 8); end
      6'b000000: begin add(m, 9); add(m, 10); end
      6'b000100: add(m, 11);
      6'b000010: add(m, 12);
      6'b001000: begin add(m, 13); add(m, 14); end
      default: begin
        e_ill[m] = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
        add(m, 15);
`endif
      end
    endcase
  endfunction

  function automatic int exp_st(int m);
    return path[m][idx[m]];
  endfunction

  // advance the model across one clock edge
  function automatic void step(int m, bit rst, bit mr,
                               logic [5:0] o);
    int cur;
    if (!rst) begin
      start_instr(m);
      e_done[m] = 1'b0;
      e_ill[m]  = 1'b0;
      return;
    end
    e_done[m] = 1'b0;
    cur = path[m][idx[m]];
    if (cur == 15) return;
    if ((cur < 4 || cur == 6 || cur == 8) && !mr) return;
    if (cur == 4) add_tail(m, o);
    idx[m]++;
    if (idx[m] == plen[m]) begin
      e_done[m] = 1'b1;
      start_instr(m);
    end
  endfunction

  task automatic cyc();
    step(0, rst_n, mr0, op0);
    step(1, rst_n, mr1, op1);
    @(posedge clk);
    @(negedge clk);
    chk("state4", st0, exp_st(0));
    chk("done4", d0, e_done[0]);
    chk("ill4", il0, e_ill[0]);
    chk("state1", st1, exp_st(1));
    chk("done1", d1, e_done[1]);
    chk("ill1", il1, e_ill[1]);
    chk("fb1_nofetch", int'(st1 >= 1 && st1 <= 3), 0);
  endtask

  logic [5:0] legal [6];
  logic [5:0] lat_op [6];
  int         lat_cy [6];

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12) return legal[r % 6];
    if (r < 14) return 6'h3f;
    return 6'($urandom);
  endfunction

  initial begin
    int cnt;
    legal  = '{6'b100000, 6'b101000, 6'b000000,
               6'b000100, 6'b000010, 6'b001000};
    lat_op = '{6'b100000, 6'b101000, 6'b000000,
               6'b001000, 6'b000100, 6'b000010};
    lat_cy = '{8, 7, 7, 7, 6, 6};
    beats  = '{4, 1};
    start_instr(0);
    start_instr(1);
    e_done = '{1'b0, 1'b0};
    e_ill  = '{1'b0, 1'b0};
    rst_n = 1'b0;
    mr0 = 1'b1; mr1 = 1'b1;
    op0 = 6'b100000; op1 = 6'b000000;
    zf  = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    rst_n = 1'b1;

    // back-to-back latency with mem_ready held high
    for (int k = 0; k < 6; k++) begin
      op0 = lat_op[k];
      cnt = 0;
      do begin
        cyc();
        cnt++;
      end while (!d0 && cnt < 40);
      chk("latency", cnt, lat_cy[k]);
    end

    // illegal opcode, then reset out of it
    op0 = 6'h3f;
    repeat (25) cyc();
    chk("ill_sticky", il0, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // reset while LBRD waits on memory
    op0 = 6'b100000;
    for (int i = 0; i < 20 && st0 != 4'd6; i++) cyc();
    chk("reach_lbrd", st0, 6);
    mr0 = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b0;
    cyc();
    chk("mid_rst", st0, 0);
    rst_n = 1'b1;
    mr0 = 1'b1;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit trapped;
      trapped = (exp_st(0) == 15) || (exp_st(1) == 15);
      rst_n = !(($urandom_range(0, 199) == 0) ||
                (trapped && $urandom_range(0, 29) == 0));
      mr0 = ($urandom_range(0, 3) != 0);
      mr1 = ($urandom_range(0, 3) != 0);
      if (exp_st(0) < 4) op0 = pick_op();
      if (exp_st(1) < 4) op1 = pick_op();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
